// File: rtl/dsm2_dac_stereo.sv
// Stereo second-order delta-sigma DAC modulator.
// Holds the latest stereo sample and runs two identical 1-bit modulators
// on a common tick produced by dividing clk by CLK_DIV.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   sample_in_rdy  one-cycle strobe qualifying sample_in_l / sample_in_r
//   sample_in_l    signed 18-bit left sample
//   sample_in_r    signed 18-bit right sample
//   dac_out_l      left PDM bit (registered)
//   dac_out_r      right PDM bit (registered)
//   dac_tick       one-cycle pulse in the cycle the PDM bits take a new value

// One modulator channel: two saturating integrators and a 1-bit quantiser.
// Ports: clk, reset, tick (state update enable), x (held input), pdm (bit out).
module dsm2_channel #(
    parameter int unsigned FS = 131072
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic signed [17:0] x,
    output logic               pdm
);

    localparam int unsigned A1_W  = 22;
    localparam int unsigned A2_W  = 24;
    localparam int unsigned SUM_W = 25;
    localparam int unsigned OV1_W = SUM_W - A1_W + 1;
    localparam int unsigned OV2_W = SUM_W - A2_W + 1;

    logic signed [A1_W-1:0]  acc1;
    logic signed [A2_W-1:0]  acc2;
    logic signed [SUM_W-1:0] fb_c;
    logic signed [SUM_W-1:0] sum1_c;
    logic signed [SUM_W-1:0] sum2_c;
    logic signed [A1_W-1:0]  acc1_next_c;
    logic signed [A2_W-1:0]  acc2_next_c;
    logic                    fit1_c;
    logic                    fit2_c;

    // Feedback follows the bit currently on the output.
    always_comb begin
        fb_c = $signed(SUM_W'(FS));
        if (!pdm) begin
            fb_c = -$signed(SUM_W'(FS));
        end
    end

    // Both integrators update from registered values (acc2 sees the old acc1).
    always_comb begin
        sum1_c = SUM_W'(acc1) + SUM_W'(x) - fb_c;
        sum2_c = SUM_W'(acc2) + SUM_W'(acc1) - fb_c;
    end

    // A sum fits when all bits above the target sign bit match the top bit;
    // otherwise clamp towards the side given by the 25-bit sign.
    always_comb begin
        fit1_c = (sum1_c[SUM_W-1 -: OV1_W] == {OV1_W{sum1_c[SUM_W-1]}});
        fit2_c = (sum2_c[SUM_W-1 -: OV2_W] == {OV2_W{sum2_c[SUM_W-1]}});

        acc1_next_c = sum1_c[A1_W-1:0];
        if (!fit1_c) begin
            acc1_next_c = {sum1_c[SUM_W-1], {(A1_W-1){~sum1_c[SUM_W-1]}}};
        end

        acc2_next_c = sum2_c[A2_W-1:0];
        if (!fit2_c) begin
            acc2_next_c = {sum2_c[SUM_W-1], {(A2_W-1){~sum2_c[SUM_W-1]}}};
        end
    end

    // Modulator state; quantiser maps zero to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc1 <= '0;
            acc2 <= '0;
            pdm  <= 1'b0;
        end else if (tick) begin
            acc1 <= acc1_next_c;
            acc2 <= acc2_next_c;
            pdm  <= ~acc2_next_c[A2_W-1];
        end
    end

endmodule

module dsm2_dac_stereo #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FS      = 131072
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_in_rdy,
    input  logic signed [17:0] sample_in_l,
    input  logic signed [17:0] sample_in_r,
    output logic               dac_out_l,
    output logic               dac_out_r,
    output logic               dac_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick_c;
    logic signed [17:0] hold_l;
    logic signed [17:0] hold_r;

    assign tick_c = (div_cnt == DIV_LAST);

    // Tick divider; dac_tick marks the cycle the channel bits change.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            dac_tick <= 1'b0;
        end else begin
            div_cnt  <= tick_c ? '0 : div_cnt + DIV_W'(1);
            dac_tick <= tick_c;
        end
    end

    // Hold registers; a strobe on a tick cycle lands after the tick has used the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (sample_in_rdy) begin
            hold_l <= sample_in_l;
            hold_r <= sample_in_r;
        end
    end

    dsm2_channel #(.FS(FS)) u_chan_l (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c),
        .x     (hold_l),
        .pdm   (dac_out_l)
    );

    dsm2_channel #(.FS(FS)) u_chan_r (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_c),
        .x     (hold_r),
        .pdm   (dac_out_r)
    );

endmodule

// File: tb/tb_dsm2_dac_stereo.sv
// Bench for dsm2_dac_stereo: a reference model pushes expected bit pairs on
// every tick; a monitor pops them whenever the DUT pulses dac_tick.
module tb_dsm2_dac_stereo;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FS      = 131072;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_in_rdy = 1'b0;
    logic signed [17:0] sample_in_l = '0;
    logic signed [17:0] sample_in_r = '0;
    logic               dac_out_l;
    logic               dac_out_r;
    logic               dac_tick;

    dsm2_dac_stereo #(.CLK_DIV(CLK_DIV), .FS(FS)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in_rdy (sample_in_rdy),
        .sample_in_l   (sample_in_l),
        .sample_in_r   (sample_in_r),
        .dac_out_l     (dac_out_l),
        .dac_out_r     (dac_out_r),
        .dac_tick      (dac_tick)
    );

    always #5 clk = ~clk;

    // reference model state
    int          mdiv = 0;
    longint      a1l = 0, a2l = 0, a1r = 0, a2r = 0;
    bit          ol = 1'b0, orr = 1'b0;
    longint      hl = 0, hr = 0;
    bit          exp_tick = 1'b0;
    int          mticks = 0;
    int          rst_gen = 0;
    logic [1:0]  sbq[$];

    // stimulus -> monitor requests
    int          win_req = 0;
    int          win_len = 0;
    int          win_exp_l = 0, win_exp_r = 0, win_tol = 0;
    bit          done_req = 1'b0;

    // monitor-owned counters
    int          vectors = 0;
    int          miscompares = 0;

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    task automatic mod_step(input longint x, input bit o_in, input longint a1_in,
                            input longint a2_in, output bit o_out,
                            output longint a1_out, output longint a2_out);
        longint fb;
        fb = o_in ? longint'(FS) : -longint'(FS);
        a1_out = clamp(a1_in + x - fb, 22);
        a2_out = clamp(a2_in + a1_in - fb, 24);
        o_out  = (a2_out >= 0);
    endtask

    // Reference model: own divider, hold and integrators.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mdiv = 0; a1l = 0; a2l = 0; a1r = 0; a2r = 0;
                ol = 1'b0; orr = 1'b0; hl = 0; hr = 0; exp_tick = 1'b0;
                rst_gen++;
            end else begin
                exp_tick = (mdiv == CLK_DIV - 1);
                if (exp_tick) begin
                    mod_step(hl, ol, a1l, a2l, ol, a1l, a2l);
                    mod_step(hr, orr, a1r, a2r, orr, a1r, a2r);
                    sbq.push_back({ol, orr});
                    mticks++;
                end
                if (sample_in_rdy) begin
                    hl = longint'(sample_in_l);
                    hr = longint'(sample_in_r);
                end
                mdiv = (mdiv == CLK_DIV - 1) ? 0 : mdiv + 1;
            end
        end
    end

    task automatic cmp(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic cmp_tol(input string name, input int got, input int want, input int tol);
        vectors++;
        if (got > want + tol || got < want - tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, want, tol);
        end
    endtask

    // Monitor: checks dac_tick timing, pops the scoreboard on each DUT tick.
    initial begin
        int         seen_gen;
        int         win_seen;
        int         win_left;
        int         ones_l, ones_r;
        int         start_idx;
        bit         startup_done;
        logic [3:0] first_l, first_r;
        logic [1:0] e;
        seen_gen = 0; win_seen = 0; win_left = 0; ones_l = 0; ones_r = 0;
        start_idx = 0; startup_done = 1'b0; first_l = '0; first_r = '0;
        forever begin
            @(negedge clk);
            if (seen_gen != rst_gen) begin
                seen_gen  = rst_gen;
                start_idx = 0;
            end
            if (win_seen != win_req) begin
                win_seen = win_req;
                win_left = win_len;
                ones_l = 0;
                ones_r = 0;
            end
            cmp("dac_tick", longint'(dac_tick), longint'(exp_tick));
            if (dac_tick) begin
                if (sbq.size() == 0) begin
                    cmp("scoreboard_depth", 0, 1);
                end else begin
                    e = sbq.pop_front();
                    cmp("dac_out_l", longint'(dac_out_l), longint'(e[1]));
                    cmp("dac_out_r", longint'(dac_out_r), longint'(e[0]));
                end
                if (win_left > 0) begin
                    ones_l += int'(dac_out_l);
                    ones_r += int'(dac_out_r);
                    win_left--;
                    if (win_left == 0) begin
                        cmp_tol("density_l", ones_l, win_exp_l, win_tol);
                        cmp_tol("density_r", ones_r, win_exp_r, win_tol);
                    end
                end
                if (!startup_done && start_idx < 4) begin
                    first_l = {first_l[2:0], dac_out_l};
                    first_r = {first_r[2:0], dac_out_r};
                    start_idx++;
                    if (start_idx == 4) begin
                        cmp("startup_l", longint'(first_l), 64'd14);
                        cmp("startup_r", longint'(first_r), 64'd14);
                        startup_done = 1'b1;
                    end
                end
            end else begin
                cmp("hold_l", longint'(dac_out_l), longint'(ol));
                cmp("hold_r", longint'(dac_out_r), longint'(orr));
            end
            if (done_req) begin
                cmp("scoreboard_left", longint'(sbq.size()), 0);
                cmp("window_open", longint'(win_left), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int t0;
        t0 = mticks;
        while (mticks < t0 + n) @(posedge clk);
    endtask

    task automatic strobe(input int l, input int r);
        @(negedge clk);
        sample_in_rdy = 1'b1;
        sample_in_l   = 18'(l);
        sample_in_r   = 18'(r);
        @(negedge clk);
        sample_in_rdy = 1'b0;
    endtask

    task automatic arm_window(input int len, input int el, input int er, input int tol);
        @(negedge clk);
        win_len   = len;
        win_exp_l = el;
        win_exp_r = er;
        win_tol   = tol;
        win_req++;
    endtask

    // Stimulus
    initial begin
        int v, w;
        // reset held 100 cycles, then zero-input run from a clean start
        repeat (100) @(negedge clk);
        arm_window(4096, 2048, 2048, 16);
        reset = 1'b0;
        wait_ticks(4098);

        // strobe landing exactly in the tick cycle
        @(negedge clk);
        while (mdiv != CLK_DIV - 1) @(negedge clk);
        sample_in_rdy = 1'b1;
        sample_in_l   = 18'(40000);
        sample_in_r   = 18'(-30000);
        @(negedge clk);
        sample_in_rdy = 1'b0;
        wait_ticks(200);

        // DC at +/- FS/2
        strobe(65536, -65536);
        wait_ticks(16);
        arm_window(4096, 3072, 1024, 16);
        wait_ticks(4100);

        // overdrive, then recovery at zero input
        strobe(131071, -131072);
        wait_ticks(2000);
        strobe(0, 0);
        wait_ticks(512);
        arm_window(4096, 2048, 2048, 64);
        wait_ticks(4100);

        // random input, back-to-back strobes, and a one-cycle reset mid-stream
        for (int i = 0; i < 60; i++) begin
            v = int'($urandom_range(131072)) - 65536;
            w = int'($urandom_range(131072)) - 65536;
            if (i % 7 == 0) begin
                @(negedge clk);
                sample_in_rdy = 1'b1;
                sample_in_l   = 18'(w);
                sample_in_r   = 18'(v);
            end
            strobe(v, w);
            repeat ($urandom_range(60, 10)) @(negedge clk);
            if (i == 30) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        wait_ticks(50);
        @(negedge clk);
        done_req = 1'b1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

endmodule
